// File: rtl/renode_ahb_sram_subordinate_if.sv
// -----------------------------------------------------------------------------
// renode_ahb_sram_subordinate_if
//
// AHB-Lite bus bundle between a manager (or a bench) and the SRAM subordinate.
//
// Signals
//   hsel       subordinate select
//   haddr      byte address (AddressWidth bits)
//   htrans     transfer type: 0 Idle, 1 Busy, 2 NonSequential, 3 Sequential
//   hwrite     1 = write
//   hsize      transfer size, 2^hsize bytes
//   hburst     burst type (carried, not interpreted by the subordinate)
//   hwdata     write data, valid in the data phase
//   hready     bus-level ready; address phases only advance while it is 1
//   hrdata     read data from the subordinate
//   hreadyout  subordinate's data-phase completion
//   hresp      0 = Okay, 1 = Error
//
// Modports
//   master  drives the request side and hready, observes the response
//   slave   observes the request side, drives hrdata/hreadyout/hresp
// -----------------------------------------------------------------------------
interface renode_ahb_sram_subordinate_if #(
   parameter int AddressWidth = 20,
   parameter int DataWidth    = 32
);
   logic                    hsel;
   logic [AddressWidth-1:0] haddr;
   logic [1:0]              htrans;
   logic                    hwrite;
   logic [2:0]              hsize;
   logic [2:0]              hburst;
   logic [DataWidth-1:0]    hwdata;
   logic                    hready;
   logic [DataWidth-1:0]    hrdata;
   logic                    hreadyout;
   logic                    hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      input  hrdata, hreadyout, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
      output hrdata, hreadyout, hresp
   );
endinterface

// File: rtl/renode_ahb_sram_subordinate.sv
// -----------------------------------------------------------------------------
// renode_ahb_sram_subordinate
//
// AHB-Lite SRAM subordinate with byte-lane writes, optional wait states and a
// two-cycle error response for illegal size / misaligned / out-of-range
// accesses. Storage is a plain array with a registered read port.
//
// Parameters
//   AddressWidth  haddr width in bits
//   DataWidth     data bus width: 8, 16, 32 or 64
//   DepthWords    number of DataWidth-bit words (power of two, >= 2)
//   WaitStates    low hreadyout cycles inserted in every Okay data phase (0..7)
//
// Ports
//   hclk     clock, rising edge
//   hresetn  synchronous active-low reset (storage contents are kept)
//   bus      AHB-Lite slave modport (see renode_ahb_sram_subordinate_if)
// -----------------------------------------------------------------------------
module renode_ahb_sram_subordinate #(
   parameter int AddressWidth = 20,
   parameter int DataWidth    = 32,
   parameter int DepthWords   = 256,
   parameter int WaitStates   = 0
) (
   input  logic                         hclk,
   input  logic                         hresetn,
   renode_ahb_sram_subordinate_if.slave bus
);

   localparam int ByteLanes = DataWidth / 8;
   localparam int LaneBits  = $clog2(ByteLanes);
   localparam int IdxBits   = $clog2(DepthWords);
   localparam int CntBits   = 3;

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   state_e                 state_q, state_d;
   logic [CntBits-1:0]     cnt_q, cnt_d;
   logic                   hreadyout_q, hreadyout_d;
   logic                   hresp_q, hresp_d;
   logic                   wr_pend_q, wr_pend_d;     // write data phase in flight
   logic [IdxBits-1:0]     wr_idx_q, wr_idx_d;
   logic [ByteLanes-1:0]   wr_mask_q, wr_mask_d;
   logic                   rd_valid_q, rd_valid_d;   // read data phase in flight
   logic [ByteLanes-1:0]   byp_mask_q, byp_mask_d;   // lanes overridden by bypass
   logic [DataWidth-1:0]   byp_data_q, byp_data_d;
   logic [DataWidth-1:0]   rd_word_q;                // registered RAM read

   logic [DataWidth-1:0]   mem [DepthWords];

   // ---------------------------------------------------------------------
   // Address-phase decode
   // ---------------------------------------------------------------------
   logic [AddressWidth-1:0] word_addr;
   logic [AddressWidth-1:0] lane_off;
   logic [AddressWidth-1:0] size_bytes;
   logic                    size_err;
   logic                    align_err;
   logic                    range_err;
   logic                    accept;
   logic                    acc_ok;
   logic                    acc_err;
   logic [IdxBits-1:0]      acc_idx;
   logic [ByteLanes-1:0]    acc_mask;
   logic                    wr_commit;
   logic                    byp_hit;
   logic [DataWidth-1:0]    rd_merged;

   always_comb begin
      word_addr  = bus.haddr >> LaneBits;
      lane_off   = bus.haddr & AddressWidth'(ByteLanes - 1);
      size_bytes = AddressWidth'(32'd1 << bus.hsize);
      size_err   = bus.hsize > 3'(LaneBits);
      align_err  = |(bus.haddr & (size_bytes - AddressWidth'(1)));
      range_err  = word_addr >= AddressWidth'(DepthWords);
      acc_idx    = word_addr[IdxBits-1:0];
      // hreadyout_q gates acceptance so a stray hready=1 during ERR1 or a
      // wait cycle cannot start a second transfer under the first one.
      accept     = hresetn & bus.hsel & bus.hready & bus.htrans[1] & hreadyout_q;
      acc_err    = accept & (size_err | align_err | range_err);
      acc_ok     = accept & ~(size_err | align_err | range_err);
      // A pending write completes exactly when hreadyout is high.
      wr_commit  = hresetn & wr_pend_q & hreadyout_q;
      byp_hit    = acc_ok & ~bus.hwrite & wr_commit & (wr_idx_q == acc_idx);
   end

   for (genvar gi = 0; gi < ByteLanes; gi++) begin : g_lane
      assign acc_mask[gi] = (AddressWidth'(gi) >= lane_off) &&
                            (AddressWidth'(gi) < lane_off + size_bytes);
      assign rd_merged[gi*8 +: 8] = byp_mask_q[gi] ? byp_data_q[gi*8 +: 8]
                                                   : rd_word_q[gi*8 +: 8];
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hreadyout_d = hreadyout_q;
      hresp_d     = hresp_q;
      wr_pend_d   = wr_pend_q;
      wr_idx_d    = wr_idx_q;
      wr_mask_d   = wr_mask_q;
      rd_valid_d  = rd_valid_q;
      byp_mask_d  = byp_mask_q;
      byp_data_d  = byp_data_q;

      if (hreadyout_q) begin
         // Idle, ERR2 or the completing WAIT cycle: the current data phase
         // ends here and a new address phase may be taken.
         state_d     = IDLE;
         hreadyout_d = 1'b1;
         hresp_d     = 1'b0;
         wr_pend_d   = 1'b0;
         rd_valid_d  = 1'b0;
         byp_mask_d  = '0;
         if (acc_err) begin
            state_d     = ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
         end else if (acc_ok) begin
            wr_pend_d  = bus.hwrite;
            rd_valid_d = ~bus.hwrite;
            wr_idx_d   = acc_idx;
            wr_mask_d  = acc_mask;
            // The write completing now lands in RAM at this same edge; keep
            // its lanes so the read sees the merged word.
            byp_mask_d = byp_hit ? wr_mask_q : '0;
            byp_data_d = bus.hwdata;
            if (WaitStates > 0) begin
               state_d     = WAIT;
               hreadyout_d = 1'b0;
               cnt_d       = CntBits'(WaitStates - 1);
            end
         end
      end else begin
         case (state_q)
            ERR1: begin
               state_d     = ERR2;
               hreadyout_d = 1'b1;
               hresp_d     = 1'b1;
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  hreadyout_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CntBits'(1);
               end
            end
            default: begin
               state_d     = IDLE;
               hreadyout_d = 1'b1;
               hresp_d     = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         wr_pend_q   <= 1'b0;
         wr_idx_q    <= '0;
         wr_mask_q   <= '0;
         rd_valid_q  <= 1'b0;
         byp_mask_q  <= '0;
         byp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         wr_pend_q   <= wr_pend_d;
         wr_idx_q    <= wr_idx_d;
         wr_mask_q   <= wr_mask_d;
         rd_valid_q  <= rd_valid_d;
         byp_mask_q  <= byp_mask_d;
         byp_data_q  <= byp_data_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage: byte-enable write, registered read, never reset
   // ---------------------------------------------------------------------
   always_ff @(posedge hclk) begin
      if (wr_commit) begin
         for (int i = 0; i < ByteLanes; i++) begin
            if (wr_mask_q[i]) begin
               mem[wr_idx_q][i*8 +: 8] <= bus.hwdata[i*8 +: 8];
            end
         end
      end
      if (acc_ok && !bus.hwrite) begin
         rd_word_q <= mem[acc_idx];
      end
   end

   assign bus.hrdata    = (rd_valid_q && hreadyout_q) ? rd_merged : '0;
   assign bus.hreadyout = hreadyout_q;
   assign bus.hresp     = hresp_q;

   // Burst type and the low htrans bit carry no meaning for single beats.
   logic unused_bits;
   assign unused_bits = ^{bus.hburst, bus.htrans[0]};

endmodule

// File: tb/tb_renode_ahb_sram_subordinate.sv
// -----------------------------------------------------------------------------
// tb_renode_ahb_sram_subordinate
//
// Two subordinates share one clock and reset: u_dut0 (no wait states) runs a
// pipelined vector table, u_dut3 (three wait states) runs hand-written
// sequences for wait-state timing and reset during a pending write.
// -----------------------------------------------------------------------------
module tb_renode_ahb_sram_subordinate;

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   logic hclk = 1'b0;
   logic hresetn;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 hclk = ~hclk;

   renode_ahb_sram_subordinate_if #(.AddressWidth(20), .DataWidth(32)) if0 ();
   renode_ahb_sram_subordinate_if #(.AddressWidth(20), .DataWidth(32)) if3 ();

   assign if0.hready = if0.hreadyout;
   assign if3.hready = if3.hreadyout;

   renode_ahb_sram_subordinate #(
      .AddressWidth(20), .DataWidth(32), .DepthWords(256), .WaitStates(0)
   ) u_dut0 (
      .hclk   (hclk),
      .hresetn(hresetn),
      .bus    (if0.slave)
   );

   renode_ahb_sram_subordinate #(
      .AddressWidth(20), .DataWidth(32), .DepthWords(256), .WaitStates(3)
   ) u_dut3 (
      .hclk   (hclk),
      .hresetn(hresetn),
      .bus    (if3.slave)
   );

   // One row = one clock: the address phase presented in this cycle, the
   // hwdata for the previous row's data phase, and the outputs expected in
   // this cycle (the data phase of the previous row).
   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [19:0] addr;
      logic [31:0] wdata;
      logic        exp_rdy;
      logic        exp_resp;
      logic [31:0] exp_rdata;
      logic [31:0] mask;
   } vec_t;

   localparam int NVEC = 33;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                               input logic [2:0] size, input logic [19:0] addr,
                               input logic [31:0] wdata, input logic rdy, input logic resp,
                               input logic [31:0] rdata, input logic [31:0] mask);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.size = size; v.addr = addr;
      v.wdata = wdata; v.exp_rdy = rdy; v.exp_resp = resp; v.exp_rdata = rdata;
      v.mask = mask;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp, input logic [31:0] mask);
      n_checks++;
      if ((act & mask) !== (exp & mask)) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act & mask, exp & mask);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle0();
      if0.hsel = 1'b0; if0.htrans = 2'd0; if0.hwrite = 1'b0; if0.hsize = 3'd0;
      if0.haddr = '0; if0.hburst = 3'd0; if0.hwdata = '0;
   endtask

   task automatic idle3();
      if3.hsel = 1'b0; if3.htrans = 2'd0; if3.hwrite = 1'b0; if3.hsize = 3'd0;
      if3.haddr = '0; if3.hburst = 3'd0;
   endtask

   // Single 32-bit transfer on u_dut3; reports the low-hreadyout count,
   // whether hresp was ever seen high, and hrdata in the completing cycle.
   task automatic ws3_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                           output int lows, output logic [31:0] rdata, output logic resp_seen);
      bit done;
      if3.hsel = 1'b1; if3.htrans = 2'd2; if3.hwrite = wr; if3.hsize = 3'd2; if3.haddr = addr;
      tick();
      idle3();
      if3.hwdata = wdata;
      lows = 0; rdata = '0; resp_seen = 1'b0; done = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge hclk);
         if (if3.hresp) resp_seen = 1'b1;
         if (if3.hreadyout) begin
            rdata = if3.hrdata;
            done  = 1'b1;
         end else begin
            lows++;
         end
         tick();
      end
      if (!done) lows = -1;
      $display("ws3 %s addr=0x%05h: lows=%0d resp_seen=%0b hrdata=0x%08h",
               wr ? "write" : "read ", addr, lows, resp_seen, rdata);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lows;
      logic [31:0] rd;
      logic        rs;

      vecs[0]  = mk(1, 2'd2, 1, 3'd2, 20'h00010, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[1]  = mk(1, 2'd2, 0, 3'd2, 20'h00010, 32'hDEADBEEF, 1, 0, 32'h0,        ALL);
      vecs[2]  = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'hDEADBEEF, ALL);
      vecs[3]  = mk(1, 2'd2, 1, 3'd2, 20'h00020, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[4]  = mk(1, 2'd2, 1, 3'd0, 20'h00020, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[5]  = mk(1, 2'd2, 1, 3'd0, 20'h00023, 32'h00000011, 1, 0, 32'h0,        ALL);
      vecs[6]  = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h22000000, 1, 0, 32'h0,        ALL);
      vecs[7]  = mk(1, 2'd2, 0, 3'd2, 20'h00020, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[8]  = mk(1, 2'd2, 0, 3'd1, 20'h00022, 32'h0,        1, 0, 32'h22000011, ALL);
      vecs[9]  = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'h22000000, 32'hFFFF0000);
      vecs[10] = mk(1, 2'd2, 1, 3'd2, 20'h00000, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[11] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h12345678, 1, 0, 32'h0,        ALL);
      vecs[12] = mk(1, 2'd2, 0, 3'd2, 20'h00002, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[13] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        0, 1, 32'h0,        ALL);
      vecs[14] = mk(1, 2'd2, 1, 3'd2, 20'h00400, 32'h0,        1, 1, 32'h0,        ALL);
      vecs[15] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'hFFFFFFFF, 0, 1, 32'h0,        ALL);
      vecs[16] = mk(1, 2'd2, 0, 3'd2, 20'h00000, 32'hFFFFFFFF, 1, 1, 32'h0,        ALL);
      vecs[17] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'h12345678, ALL);
      vecs[18] = mk(1, 2'd2, 0, 3'd3, 20'h00008, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[19] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        0, 1, 32'h0,        ALL);
      vecs[20] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 1, 32'h0,        ALL);
      vecs[21] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[22] = mk(1, 2'd2, 1, 3'd2, 20'h00040, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[23] = mk(1, 2'd2, 0, 3'd2, 20'h00040, 32'hA5A5A5A5, 1, 0, 32'h0,        ALL);
      vecs[24] = mk(1, 2'd2, 1, 3'd0, 20'h00041, 32'h0,        1, 0, 32'hA5A5A5A5, ALL);
      vecs[25] = mk(1, 2'd2, 0, 3'd2, 20'h00040, 32'h00007700, 1, 0, 32'h0,        ALL);
      vecs[26] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'hA5A577A5, ALL);
      vecs[27] = mk(0, 2'd2, 1, 3'd2, 20'h00040, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[28] = mk(1, 2'd1, 1, 3'd2, 20'h00040, 32'hFFFFFFFF, 1, 0, 32'h0,        ALL);
      vecs[29] = mk(1, 2'd2, 0, 3'd2, 20'h00040, 32'hFFFFFFFF, 1, 0, 32'h0,        ALL);
      vecs[30] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'hA5A577A5, ALL);
      vecs[31] = mk(1, 2'd3, 0, 3'd2, 20'h00010, 32'h0,        1, 0, 32'h0,        ALL);
      vecs[32] = mk(0, 2'd0, 0, 3'd0, 20'h00000, 32'h0,        1, 0, 32'hDEADBEEF, ALL);

      // Reset
      hresetn = 1'b0;
      idle0();
      idle3();
      if3.hwdata = '0;
      repeat (3) tick();
      @(negedge hclk);
      check("reset dut0 hreadyout", 32'(if0.hreadyout), 32'd1, ALL);
      check("reset dut0 hresp",     32'(if0.hresp),     32'd0, ALL);
      check("reset dut0 hrdata",    if0.hrdata,         32'h0, ALL);
      check("reset dut3 hreadyout", 32'(if3.hreadyout), 32'd1, ALL);
      check("reset dut3 hresp",     32'(if3.hresp),     32'd0, ALL);
      check("reset dut3 hrdata",    if3.hrdata,         32'h0, ALL);
      tick();
      hresetn = 1'b1;

      // Pipelined vector table on the zero-wait instance
      for (int i = 0; i < NVEC; i++) begin
         if0.hsel = vecs[i].sel; if0.htrans = vecs[i].trans; if0.hwrite = vecs[i].wr;
         if0.hsize = vecs[i].size; if0.haddr = vecs[i].addr; if0.hwdata = vecs[i].wdata;
         @(negedge hclk);
         $display("vec %0d: sel=%0b trans=%0d wr=%0b size=%0d addr=0x%05h wdata=0x%08h -> rdy=%0b resp=%0b hrdata=0x%08h",
                  i, vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr,
                  vecs[i].wdata, if0.hreadyout, if0.hresp, if0.hrdata);
         check($sformatf("vec%0d hreadyout", i), 32'(if0.hreadyout), 32'(vecs[i].exp_rdy), ALL);
         check($sformatf("vec%0d hresp", i),     32'(if0.hresp),     32'(vecs[i].exp_resp), ALL);
         check($sformatf("vec%0d hrdata", i),    if0.hrdata,         vecs[i].exp_rdata, vecs[i].mask);
         tick();
      end
      idle0();

      // Three wait states: write then read back
      ws3_xfer(1'b1, 20'h00030, 32'h5A5A1234, lows, rd, rs);
      check("ws3 write low cycles", 32'(lows), 32'd3, ALL);
      check("ws3 write hresp",      32'(rs),   32'd0, ALL);
      ws3_xfer(1'b0, 20'h00030, 32'h0, lows, rd, rs);
      check("ws3 read low cycles",  32'(lows), 32'd3, ALL);
      check("ws3 read hresp",       32'(rs),   32'd0, ALL);
      check("ws3 read hrdata",      rd,        32'h5A5A1234, ALL);

      // Reset in the middle of a waited write
      if3.hsel = 1'b1; if3.htrans = 2'd2; if3.hwrite = 1'b1; if3.hsize = 3'd2;
      if3.haddr = 20'h00030;
      tick();
      idle3();
      if3.hwdata = 32'hCAFEF00D;
      @(negedge hclk);
      check("ws3 pending write waiting", 32'(if3.hreadyout), 32'd0, ALL);
      tick();
      hresetn = 1'b0;
      tick();
      @(negedge hclk);
      $display("ws3 reset during write: rdy=%0b resp=%0b hrdata=0x%08h",
               if3.hreadyout, if3.hresp, if3.hrdata);
      check("ws3 after reset hreadyout", 32'(if3.hreadyout), 32'd1, ALL);
      check("ws3 after reset hresp",     32'(if3.hresp),     32'd0, ALL);
      check("ws3 after reset hrdata",    if3.hrdata,         32'h0, ALL);
      // An address phase presented while reset is low must not be taken.
      if3.hsel = 1'b1; if3.htrans = 2'd2; if3.hwrite = 1'b0; if3.hsize = 3'd2;
      if3.haddr = 20'h00030;
      tick();
      idle3();
      hresetn = 1'b1;
      @(negedge hclk);
      $display("ws3 address during reset: rdy=%0b resp=%0b", if3.hreadyout, if3.hresp);
      check("ws3 no accept in reset", 32'(if3.hreadyout), 32'd1, ALL);
      tick();
      tick();
      ws3_xfer(1'b0, 20'h00030, 32'h0, lows, rd, rs);
      check("ws3 post-reset low cycles", 32'(lows), 32'd3, ALL);
      check("ws3 post-reset hrdata",     rd,        32'h5A5A1234, ALL);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/renode_ahb_sram_subordinate.md
RENODE_AHB_SRAM_SUBORDINATE -- requirements
Module: renode_ahb_sram_subordinate

Interface
REQ-001 SHALL provide parameter AddressWidth, default 20, meaning the haddr width in bits.
REQ-002 SHALL provide parameter DataWidth, default 32, meaning the hrdata/hwdata width in bits; legal values are 8, 16, 32 and 64.
REQ-003 SHALL provide parameter DepthWords, default 256, meaning the number of DataWidth-bit words of storage; must be a power of two.
REQ-004 SHALL provide parameter WaitStates, default 0, range 0..7, meaning the number of low hreadyout cycles inserted in each OKAY data phase.
REQ-005 SHALL have port hclk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 SHALL have port hresetn, input, 1 bit: the reset, which is synchronous and active-low.
REQ-007 SHALL have port hsel, input, 1 bit: subordinate select.
REQ-008 SHALL have port haddr, input, AddressWidth bits: byte address.
REQ-009 SHALL have port htrans, input, 2 bits: Idle=0, Busy=1, NonSequential=2, Sequential=3.
REQ-010 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-011 SHALL have port hsize, input, 3 bits: the transfer is 2^hsize bytes.
REQ-012 SHALL have port hburst, input, 3 bits: accepted and ignored; every beat is handled as a single transfer.
REQ-013 SHALL have port hwdata, input, DataWidth bits: write data, valid in the data phase.
REQ-014 SHALL have port hready, input, 1 bit: bus-level ready; an address phase is sampled only when it is 1.
REQ-015 SHALL have port hrdata, output, DataWidth bits: read data.
REQ-016 SHALL have port hreadyout, output, 1 bit: completion of the data phase.
REQ-017 SHALL have port hresp, output, 1 bit: 0 = Okay, 1 = Error.

Function
REQ-018 SHALL accept an address phase on a rising edge at which hsel=1, hready=1 and htrans[1]=1.
REQ-019 On acceptance, SHALL register haddr, hsize and hwrite for use in the following data phase.
REQ-020 SHALL treat Idle or Busy transfers, or hsel=0, as no transfer, giving a zero-wait Okay response with no storage access.
REQ-021 SHALL flag an accepted transfer as an error if any of these holds:
 - hsize exceeds log2(DataWidth/8);
 - haddr is not aligned to 2^hsize;
 - haddr/(DataWidth/8) >= DepthWords.
REQ-022 SHALL implement four FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-023 SHALL make the IDLE -> WAIT transition on an accepted non-error transfer when WaitStates>0.
REQ-024 SHALL stay in IDLE on an accepted non-error transfer when WaitStates=0; that data phase completes in the next cycle.
REQ-025 SHALL count WaitStates cycles in WAIT with hreadyout=0, then drive hreadyout=1 for one cycle and return to IDLE, or complete and accept a new address phase in that same cycle.
REQ-026 SHALL make the IDLE -> ERR1 transition on an accepted error transfer.
REQ-027 SHALL drive hresp=1 and hreadyout=0 in ERR1, then go to ERR2.
REQ-028 SHALL drive hresp=1 and hreadyout=1 in ERR2, then go to IDLE, accepting a new address phase in ERR2 as for IDLE.
REQ-029 SHALL ignore wait states for error responses; an error response is always exactly 2 cycles.
REQ-030 SHALL drive hresp=0 in IDLE and WAIT.
REQ-031 SHALL make hrdata valid in the cycle where hreadyout=1 for a non-error read.
REQ-032 SHALL return the full addressed word on hrdata; unused lanes are don't-care and the bench compares only the accessed lanes.
REQ-033 SHALL drive hrdata to 0 for error transfers and non-transfers.
REQ-034 SHALL commit a write on the edge ending its completing data-phase cycle.
REQ-035 SHALL write only the byte lanes selected by haddr[log2(DataWidth/8)-1:0] and hsize; other lanes are unchanged.
REQ-036 SHALL, for a read whose address phase coincides with the completing data phase of a write to the same word, return the merged new data (bypass).
REQ-037 SHALL perform no storage access and leave storage unchanged for an error transfer.
REQ-038 SHALL support back-to-back transfers with no idle cycle in between.

Reset
REQ-039 SHALL, when hresetn=0 at an edge, set FSM=IDLE, wait counter=0, hreadyout=1, hresp=0 and hrdata=0.
REQ-040 SHALL discard any pending data phase on reset, including an uncommitted write.
REQ-041 SHALL not clear storage contents on reset.
REQ-042 SHALL accept no address phase in a cycle where hresetn=0.

Verification
REQ-043 Bench SHALL check, with WaitStates=0: write 32-bit 0xDEADBEEF to 0x10, then read 0x10 -> hreadyout never low, hrdata=0xDEADBEEF, hresp=0.
REQ-044 Bench SHALL check, with WaitStates=3: a read -> exactly 3 cycles of hreadyout=0, then hreadyout=1 with data and hresp=0.
REQ-045 Bench SHALL check byte writes 0x11 @0x20 and 0x22 @0x23 over initial word 0x00000000, then a 32-bit read @0x20 -> 0x22000011.
REQ-046 Bench SHALL check a misaligned 32-bit read @0x02 and an address @DepthWords*4 -> each gives cycle 1 hresp=1/hreadyout=0, cycle 2 hresp=1/hreadyout=1, with storage unchanged.
REQ-047 Bench SHALL check a write of 0xA5A5A5A5 @0x40 immediately followed by a pipelined read @0x40 -> the read returns 0xA5A5A5A5.
REQ-048 Bench SHALL check hresetn=0 during a WaitStates=3 write -> the next cycle has hreadyout=1 and hresp=0, and a later read of that address returns its old value.
